// File: rtl/pc_gen_pkg.sv
// Shared types and default constants for the fetch PC generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } pcgen_state_e;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = '0;
  localparam int unsigned INC_DEF      = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push/pop/top/empty with a flush that empties it.
module pc_ras #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [XLEN-1:0] push_addr_i,
  input  logic            pop_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   top_q;
  logic [PW:0]     cnt_q;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic            repl;

  assign empty_o = (cnt_q == '0);
  assign top_o   = mem_q[top_q];
  assign repl    = push_i && pop_i && !empty_o;

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = top_q;
    if (!rst_i && !flush_i) begin
      if (repl) begin
        wr_en  = 1'b1;
        wr_idx = top_q;
      end else if (push_i) begin
        wr_en  = 1'b1;
        wr_idx = top_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_idx] <= push_addr_i;
  end

  // A push onto a full stack advances top over the oldest entry; count saturates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      top_q <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else if (repl) begin
      top_q <= top_q;
    end else if (push_i) begin
      top_q <= top_q + 1'b1;
      if (cnt_q != FULL) cnt_q <= cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      top_q <= top_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: prioritised redirects, optional RAS prediction, BOOT/RUN/HALT FSM.
// Define PC_GEN_RAS_EN to build the return-address stack and pop prediction.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int unsigned N_REDIR   = 2,
  parameter int unsigned INC       = INC_DEF,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REDIR-1:0]      redir_valid,
  input  logic [N_REDIR*XLEN-1:0] redir_target,
  input  logic                    stall,
  input  logic                    halt_req,
  input  logic                    resume,
  output logic [XLEN-1:0]         pc,
  output logic                    pc_valid,
  input  logic                    pc_ready,
  input  logic                    ras_push,
  input  logic [XLEN-1:0]         ras_push_addr,
  input  logic                    ras_pop,
  output logic                    ras_empty
);

  localparam logic [XLEN-1:0] INC_X = XLEN'(INC);

  pcgen_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic            pc_valid_q;
  logic            boot_wait_q;

  logic            redir_any;
  logic [XLEN-1:0] redir_pc;
  logic            acc;
  logic            halt_hold;
  logic            ras_hit;
  logic [XLEN-1:0] ras_top;

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign acc      = pc_valid_q & pc_ready & ~stall;
  assign halt_hold = (state_q == RUN) && halt_req;

  always_comb begin
    redir_any = 1'b0;
    redir_pc  = '0;
    for (int unsigned i = 0; i < N_REDIR; i++) begin
      if (redir_valid[i] && !redir_any) begin
        redir_any = 1'b1;
        redir_pc  = redir_target[i*XLEN +: XLEN];
      end
    end
  end

`ifdef PC_GEN_RAS_EN
  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (redir_valid[0]),
    .push_i      (ras_push),
    .push_addr_i (ras_push_addr),
    .pop_i       (ras_pop),
    .top_o       (ras_top),
    .empty_o     (ras_empty)
  );
  assign ras_hit = acc & ras_pop & ~ras_empty;
`else
  logic unused_ras;
  assign unused_ras = ^{ras_push, ras_push_addr, ras_pop};
  assign ras_empty  = 1'b1;
  assign ras_top    = '0;
  assign ras_hit    = 1'b0;
`endif

  // BOOT spends one full cycle after reset release before fetching starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      pc_valid_q  <= 1'b0;
      boot_wait_q <= 1'b1;
    end else begin
      if (redir_any)      pc_q <= redir_pc;
      else if (halt_hold) pc_q <= pc_q;
      else if (ras_hit)   pc_q <= ras_top;
      else if (acc)       pc_q <= pc_q + INC_X;

      case (state_q)
        BOOT: begin
          if (boot_wait_q) begin
            boot_wait_q <= 1'b0;
          end else begin
            state_q    <= RUN;
            pc_valid_q <= 1'b1;
          end
        end
        RUN: begin
          if (halt_req && !redir_any) begin
            state_q    <= HALT;
            pc_valid_q <= 1'b0;
          end
        end
        HALT: begin
          if (resume && !redir_any) begin
            state_q    <= RUN;
            pc_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= BOOT;
          pc_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed plan steps then random traffic against a reference model.
module tb_pc_gen;

  localparam int          XLEN   = 32;
  localparam int          NR     = 2;
  localparam int          DEPTH  = 4;
  localparam int          INCR   = 4;
  localparam logic [31:0] RST_PC = 32'h0;
`ifdef PC_GEN_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      redir_valid;
  logic [NR*XLEN-1:0] redir_target;
  logic               stall, halt_req, resume, pc_ready;
  logic               ras_push, ras_pop;
  logic [XLEN-1:0]    ras_push_addr;
  logic [XLEN-1:0]    pc;
  logic               pc_valid, ras_empty;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [31:0] m_pc;
  int          m_boot;
  bit          m_halted;
  logic [31:0] m_stack[$];

  pc_gen #(
    .XLEN      (XLEN),
    .RESET_PC  (RST_PC),
    .N_REDIR   (NR),
    .INC       (INCR),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redir_valid   (redir_valid),
    .redir_target  (redir_target),
    .stall         (stall),
    .halt_req      (halt_req),
    .resume        (resume),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .pc_ready      (pc_ready),
    .ras_push      (ras_push),
    .ras_push_addr (ras_push_addr),
    .ras_pop       (ras_pop),
    .ras_empty     (ras_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int          ridx;
    bit          acc, empty, running;
    logic [31:0] npc, top;
    if (rst) begin
      m_pc = RST_PC; m_boot = 2; m_halted = 1'b0; m_stack.delete();
      return;
    end
    ridx = -1;
    for (int i = 0; i < NR; i++) if (redir_valid[i] && ridx < 0) ridx = i;
    running = (m_boot == 0) && !m_halted;
    acc     = running && pc_ready && !stall;
    empty   = !RAS_EN || (m_stack.size() == 0);
    top     = empty ? 32'h0 : m_stack[$];
    npc     = m_pc;
    if (ridx >= 0)                    npc = redir_target[ridx*XLEN +: XLEN];
    else if (running && halt_req)     npc = m_pc;
    else if (acc && ras_pop && !empty) npc = top;
    else if (acc)                     npc = m_pc + INCR;
    if (m_boot > 0) m_boot--;
    else if (!m_halted) begin
      if (halt_req && ridx < 0) m_halted = 1'b1;
    end else if (resume && ridx < 0) m_halted = 1'b0;
    if (RAS_EN) begin
      if (redir_valid[0]) m_stack.delete();
      else if (ras_push && ras_pop && !empty) m_stack[m_stack.size()-1] = ras_push_addr;
      else if (ras_push) begin
        m_stack.push_back(ras_push_addr);
        if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
      end else if (ras_pop && !empty) void'(m_stack.pop_back());
    end
    m_pc = npc;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("pc_valid", {31'b0, pc_valid}, {31'b0, (m_boot == 0) && !m_halted});
    check("ras_empty", {31'b0, ras_empty}, {31'b0, !RAS_EN || (m_stack.size() == 0)});
  endtask

  task automatic idle();
    rst = 0; redir_valid = '0; redir_target = '0; stall = 0; halt_req = 0;
    resume = 0; pc_ready = 1; ras_push = 0; ras_pop = 0; ras_push_addr = '0;
  endtask

  task automatic redirect(input int idx, input logic [31:0] tgt);
    redir_valid[idx] = 1'b1;
    redir_target[idx*XLEN +: XLEN] = tgt;
  endtask

  initial begin
    idle();
    rst = 1;
    cycle(); cycle();
    check("reset_pc", pc, 32'h0);
    check("reset_valid", {31'b0, pc_valid}, 32'h0);
    check("reset_ras_empty", {31'b0, ras_empty}, 32'h1);
    // 1: boot latency and sequential fetch, then mid-stream reset
    rst = 0;
    cycle(); check("boot_valid", {31'b0, pc_valid}, 32'h0);
    cycle(); check("first_pc", pc, 32'h0);
    cycle(); cycle(); cycle(); check("seq_pc12", pc, 32'hC);
    rst = 1; cycle(); check("midrst_pc", pc, 32'h0); check("midrst_valid", {31'b0, pc_valid}, 32'h0);
    rst = 0; cycle(); cycle(); cycle(); cycle(); check("seq_pc8", pc, 32'h8);
    // 2: backpressure then stall
    pc_ready = 0;
    repeat (3) begin cycle(); check("bp_hold", pc, 32'h8); end
    pc_ready = 1; stall = 1;
    repeat (2) begin cycle(); check("stall_hold", pc, 32'h8); end
    stall = 0; cycle(); check("stall_release", pc, 32'hC);
    // 3: redirect priority
    pc_ready = 0; redirect(0, 32'h100); redirect(1, 32'h200);
    cycle(); check("redir_prio", pc, 32'h100);
    redir_valid = 2'b10; cycle(); check("redir_src1", pc, 32'h200);
    // 4: halt / resume
    idle(); redirect(0, 32'h40); cycle(); check("pre_halt", pc, 32'h40);
    idle(); halt_req = 1; cycle();
    check("halt_valid", {31'b0, pc_valid}, 32'h0); check("halt_pc", pc, 32'h40);
    idle(); redirect(1, 32'h80); cycle();
    check("halt_redir", pc, 32'h80); check("halt_stays", {31'b0, pc_valid}, 32'h0);
    idle(); resume = 1; cycle();
    check("resume_valid", {31'b0, pc_valid}, 32'h1); check("resume_pc", pc, 32'h80);
    idle(); cycle(); check("resume_inc", pc, 32'h84);
    // 5: return-address stack
`ifdef PC_GEN_RAS_EN
    idle(); pc_ready = 0; ras_push = 1;
    for (int k = 1; k <= 5; k++) begin ras_push_addr = 32'(k * 16); cycle(); end
    idle(); ras_pop = 1;
    for (int k = 5; k >= 2; k--) begin cycle(); check("ras_pop", pc, 32'(k * 16)); end
    cycle(); check("ras_empty_pop", pc, 32'h24); check("ras_empty_flag", {31'b0, ras_empty}, 32'h1);
    idle(); pc_ready = 0; ras_push = 1;
    ras_push_addr = 32'h10; cycle(); ras_push_addr = 32'h20; cycle();
    pc_ready = 1; ras_pop = 1; ras_push_addr = 32'h99; cycle(); check("ras_swap_pred", pc, 32'h20);
    idle(); ras_pop = 1; cycle(); check("ras_swap_top", pc, 32'h99);
`else
    idle(); ras_push = 1; ras_push_addr = 32'h500; cycle();
    idle(); ras_pop = 1; cycle(); check("noras_pop_inc", pc, 32'h8C);
    check("noras_empty", {31'b0, ras_empty}, 32'h1);
`endif
    // 6: wrap-around
    idle(); pc_ready = 0; redirect(1, 32'hFFFF_FFFC); cycle(); check("wrap_pre", pc, 32'hFFFF_FFFC);
    idle(); cycle(); check("wrap_zero", pc, 32'h0);
    // random traffic
    for (int n = 0; n < 600; n++) begin
      rst           = ($urandom_range(99) == 0);
      redir_valid[0] = ($urandom_range(11) == 0);
      redir_valid[1] = ($urandom_range(7) == 0);
      redir_target  = {$urandom() & 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFFC};
      stall         = ($urandom_range(3) == 0);
      pc_ready      = ($urandom_range(3) != 0);
      halt_req      = ($urandom_range(15) == 0);
      resume        = ($urandom_range(3) == 0);
      ras_push      = ($urandom_range(4) == 0);
      ras_pop       = ($urandom_range(4) == 0);
      ras_push_addr = $urandom() & 32'hFFFF_FFFC;
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
